// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full adder (two half adders plus an OR)
// adds two WIDTH-bit operands LSB-first, one bit per clock, behind start/busy/done.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh, psum, psum_n;
  logic [CW-1:0]    cnt;
  logic             carry, carry_n;
  logic             ha0_s, ha0_c, ha1_c, sbit;
  logic             last;

  // Full adder on the current LSBs and stored carry
  half_adder u_ha0 (.a(a_sh[0]), .b(b_sh[0]), .s(ha0_s), .c(ha0_c));
  half_adder u_ha1 (.a(ha0_s),   .b(carry),   .s(sbit),  .c(ha1_c));

  assign carry_n = ha0_c | ha1_c;
  assign psum_n  = {sbit, psum[WIDTH-1:1]};
  assign last    = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last)  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          psum  <= psum_n;
          carry <= carry_n;
          cnt   <= cnt + CW'(1);
          // Final bit: publish the sum including this bit and the new carry
          if (last) begin
            sum  <= psum_n;
            cout <= carry_n;
            cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl at WIDTH=8 and WIDTH=16.

module tb_serial_add_ctrl;
  logic        clk = 1'b0;
  logic        rst8, start8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        rst16, start16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst16), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One 8-bit addition started from IDLE; checks busy length, done pulse and result.
  task automatic run8(input string nm, input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] es, input logic ec);
    int n = 0;
    int nbusy = 0;
    int both = 0;
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = ~av; b8 = ~bv;
    while (!done8 && n < 40) begin
      if (busy8) nbusy++;
      @(negedge clk);
      n++;
    end
    if (busy8 && done8) both++;
    chk({nm, "_done_seen"}, done8, 1'b1);
    chk({nm, "_busy_cycles"}, nbusy, 8);
    chk({nm, "_sum"}, sum8, es);
    chk({nm, "_cout"}, cout8, ec);
    @(negedge clk);
    if (busy8 && done8) both++;
    chk({nm, "_done_one_cycle"}, done8, 1'b0);
    chk({nm, "_busy_done_overlap"}, both, 0);
  endtask

  initial begin
    int t_done[$];
    int n, ndone, hold_bad, both;
    logic [16:0] exp17;
    logic [8:0]  exp9;

    tbl[0] = '{8'h35, 8'h4A, 8'h7F, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    tbl[3] = '{8'h10, 8'h20, 8'h30, 1'b0};
    tbl[4] = '{8'hAA, 8'h55, 8'hFF, 1'b0};
    tbl[5] = '{8'h00, 8'h00, 8'h00, 1'b0};
    tbl[6] = '{8'h7F, 8'h01, 8'h80, 1'b0};
    tbl[7] = '{8'hC8, 8'h64, 8'h2C, 1'b1};
    tbl[8] = '{8'h80, 8'h80, 8'h00, 1'b1};
    tbl[9] = '{8'h0F, 8'h01, 8'h10, 1'b0};

    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
    rst16 = 1'b1; start16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_sum", sum8, 8'h00);
    chk("rst_cout", cout8, 1'b0);
    rst8 = 1'b0; rst16 = 1'b0;

    for (int i = 0; i < 10; i++)
      run8($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c);

    // Start pulsed while busy must be ignored
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      if (done8) begin
        ndone++;
        chk("busy_start_sum", sum8, 8'h30);
        chk("busy_start_cout", cout8, 1'b0);
      end
      @(negedge clk);
    end
    chk("busy_start_done_count", ndone, 1);

    // Start held high back-to-back; operands change after first acceptance
    a8 = 8'h01; b8 = 8'h02; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80;
    hold_bad = 0;
    for (int c = 1; c < 40 && t_done.size() < 2; c++) begin
      if (done8) begin
        t_done.push_back(c);
        if (t_done.size() == 1) begin
          chk("b2b_sum1", sum8, 8'h03);
          chk("b2b_cout1", cout8, 1'b0);
        end else begin
          chk("b2b_sum2", sum8, 8'h00);
          chk("b2b_cout2", cout8, 1'b1);
          start8 = 1'b0;
        end
      end else if (t_done.size() == 1 && (sum8 !== 8'h03 || cout8 !== 1'b0)) begin
        hold_bad++;
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    chk("b2b_done_count", t_done.size(), 2);
    if (t_done.size() == 2) chk("b2b_interval", t_done[1] - t_done[0], 10);
    chk("b2b_sum_hold", hold_bad, 0);
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-operation
    a8 = 8'h0F; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst8 = 1'b1;
    #1;
    chk("midrst_busy", busy8, 1'b0);
    chk("midrst_done", done8, 1'b0);
    chk("midrst_sum", sum8, 8'h00);
    chk("midrst_cout", cout8, 1'b0);
    @(negedge clk);
    rst8 = 1'b0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (done8 || busy8) ndone++;
      @(negedge clk);
    end
    chk("midrst_no_activity", ndone, 0);
    run8("after_rst", 8'h0F, 8'h01, 8'h10, 1'b0);

    // Random regression, WIDTH=8
    both = 0;
    for (int k = 0; k < 1000; k++) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      exp9 = {1'b0, a8} + {1'b0, b8};
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      n = 0;
      while (!done8 && n < 30) begin
        if (busy8 && done8) both++;
        @(negedge clk);
        n++;
      end
      chk("rand8", {cout8, sum8}, exp9);
      repeat ($urandom_range(1, 3)) begin
        if (busy8 && done8) both++;
        @(negedge clk);
      end
    end
    chk("rand8_overlap", both, 0);

    // Random regression, WIDTH=16
    both = 0;
    for (int k = 0; k < 1000; k++) begin
      a16 = 16'($urandom); b16 = 16'($urandom);
      exp17 = {1'b0, a16} + {1'b0, b16};
      start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      n = 0;
      while (!done16 && n < 40) begin
        if (busy16 && done16) both++;
        @(negedge clk);
        n++;
      end
      chk("rand16", {cout16, sum16}, exp17);
      repeat ($urandom_range(1, 3)) begin
        if (busy16 && done16) both++;
        @(negedge clk);
      end
    end
    chk("rand16_overlap", both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
